// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage and its branch target buffer.
package if_fetch_pkg;

  localparam int unsigned HOLD_FLAG_W = 3;

  localparam logic [HOLD_FLAG_W-1:0] HOLD_NONE = 3'b000;
  localparam logic [HOLD_FLAG_W-1:0] HOLD_PC   = 3'b001;
  localparam logic [HOLD_FLAG_W-1:0] HOLD_IF   = 3'b010;
  localparam logic [HOLD_FLAG_W-1:0] HOLD_ID   = 3'b011;

  localparam logic PREDICT_TAKEN     = 1'b1;
  localparam logic PREDICT_NOT_TAKEN = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    CntSnt = 2'd0,
    CntWnt = 2'd1,
    CntWt  = 2'd2,
    CntSt  = 2'd3
  } btb_cnt_e;

  // Two-bit saturating counter step.
  function automatic btb_cnt_e cnt_update(input btb_cnt_e cnt, input logic taken);
    btb_cnt_e res;
    res = cnt;
    if (taken) begin
      if (cnt != CntSt) res = btb_cnt_e'(cnt + 2'd1);
    end else begin
      if (cnt != CntSnt) res = btb_cnt_e'(cnt - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/if_fetch_bpu_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC and
// clocked training from resolved branches. Lookup always sees pre-update state.
module if_fetch_bpu_btb
  import if_fetch_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc_i,
  output logic        predict_taken_o,
  output logic [31:0] predict_addr_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX - 2;

  logic                 valid_q  [BTB_ENTRIES];
  logic     [TAG_W-1:0] tag_q    [BTB_ENTRIES];
  logic          [31:0] target_q [BTB_ENTRIES];
  btb_cnt_e             cnt_q    [BTB_ENTRIES];

  logic [IDX-1:0]   rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic [IDX-1:0]   wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  logic             unused_pc_lsb;

  assign rd_idx = lookup_pc_i[IDX+1:2];
  assign rd_tag = lookup_pc_i[31:IDX+2];
  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

  assign predict_taken_o = rd_hit ? cnt_q[rd_idx][1] : PREDICT_NOT_TAKEN;
  assign predict_addr_o  = rd_hit ? target_q[rd_idx] : ZERO_WORD;

  assign wr_idx = upd_pc_i[IDX+1:2];
  assign wr_tag = upd_pc_i[31:IDX+2];
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  assign unused_pc_lsb = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= ZERO_WORD;
        cnt_q[i]    <= CntWnt;
      end
    end else if (upd_valid_i) begin
      if (wr_hit) begin
        cnt_q[wr_idx] <= cnt_update(cnt_q[wr_idx], upd_taken_i);
        if (upd_taken_i) target_q[wr_idx] <= upd_target_i;
      end else if (upd_taken_i) begin
        // Allocation evicts whatever aliased into this slot.
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= upd_target_i;
        cnt_q[wr_idx]    <= CntWt;
      end
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, next-PC selection and optional BTB prediction.
// The BTB is built only when IF_BPU_EN is defined; otherwise predictions are tied off.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jump_flag_i,
  input  logic            [31:0] jump_addr_i,
  input  logic [HOLD_FLAG_W-1:0] hold_flag_i,
  input  logic                   upd_valid_i,
  input  logic            [31:0] upd_pc_i,
  input  logic                   upd_taken_i,
  input  logic            [31:0] upd_target_i,
  output logic            [31:0] pc_o,
  output logic                   predict_taken_o,
  output logic            [31:0] predict_addr_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

`ifdef IF_BPU_EN
  if_fetch_bpu_btb #(
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_bpu_btb (
    .clk            (clk),
    .rst            (rst),
    .lookup_pc_i    (pc_q),
    .predict_taken_o(predict_taken_o),
    .predict_addr_o (predict_addr_o),
    .upd_valid_i    (upd_valid_i),
    .upd_pc_i       (upd_pc_i),
    .upd_taken_i    (upd_taken_i),
    .upd_target_i   (upd_target_i)
  );
`else
  logic        unused_upd;
  logic [31:0] unused_btb_entries;

  assign unused_upd         = ^{upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i};
  assign unused_btb_entries = BTB_ENTRIES;
  assign predict_taken_o    = PREDICT_NOT_TAKEN;
  assign predict_addr_o     = ZERO_WORD;
`endif

  // A redirect wins over a stall; a stall wins over a prediction.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (jump_flag_i) begin
      pc_d = jump_addr_i;
    end else if (hold_flag_i >= HOLD_PC) begin
      pc_d = pc_q;
    end else if (predict_taken_o) begin
      pc_d = predict_addr_o;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch; expectations follow IF_BPU_EN.
module tb_if_fetch;
  import if_fetch_pkg::*;

`ifdef IF_BPU_EN
  localparam bit Bpu = 1'b1;
`else
  localparam bit Bpu = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic                   jump_flag_i;
  logic            [31:0] jump_addr_i;
  logic [HOLD_FLAG_W-1:0] hold_flag_i;
  logic                   upd_valid_i;
  logic            [31:0] upd_pc_i;
  logic                   upd_taken_i;
  logic            [31:0] upd_target_i;
  logic            [31:0] pc_o;
  logic                   predict_taken_o;
  logic            [31:0] predict_addr_o;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  if_fetch #(
    .BTB_ENTRIES(16),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .jump_flag_i    (jump_flag_i),
    .jump_addr_i    (jump_addr_i),
    .hold_flag_i    (hold_flag_i),
    .upd_valid_i    (upd_valid_i),
    .upd_pc_i       (upd_pc_i),
    .upd_taken_i    (upd_taken_i),
    .upd_target_i   (upd_target_i),
    .pc_o           (pc_o),
    .predict_taken_o(predict_taken_o),
    .predict_addr_o (predict_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value expected only when the predictor is built.
  function automatic logic [31:0] bp(input logic [31:0] v);
    return Bpu ? v : 32'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    jump_flag_i = 1'b1;
    jump_addr_i = addr;
    step();
    jump_flag_i = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid_i  = 1'b1;
    upd_pc_i     = pc;
    upd_taken_i  = taken;
    upd_target_i = tgt;
  endtask

  initial begin
    rst          = 1'b0;
    jump_flag_i  = 1'b0;
    jump_addr_i  = '0;
    hold_flag_i  = HOLD_NONE;
    upd_valid_i  = 1'b0;
    upd_pc_i     = '0;
    upd_taken_i  = 1'b0;
    upd_target_i = '0;

    #3;
    check("reset_pc", pc_o, 32'h0);
    check("reset_pt", {31'b0, predict_taken_o}, 32'h0);
    check("reset_pa", predict_addr_o, 32'h0);
    step();
    rst = 1'b1;
    check("release_pc", pc_o, 32'h0);

    // Sequential fetch
    step(); check("seq_pc4", pc_o, 32'h4);
    step(); check("seq_pc8", pc_o, 32'h8);
    step(); check("seq_pc12", pc_o, 32'hC);
    check("seq_pt", {31'b0, predict_taken_o}, 32'h0);
    step(); check("seq_pc16", pc_o, 32'h10);

    // Hold, then jump overriding hold
    hold_flag_i = HOLD_PC;
    for (int i = 0; i < 3; i++) begin
      step(); check("hold_pc", pc_o, 32'h10);
    end
    jump_to(32'h80);
    check("jump_over_hold", pc_o, 32'h80);
    hold_flag_i = HOLD_NONE;

    // Allocate 0x20 -> 0x100
    train(32'h20, 1'b1, 32'h100);
    step();
    upd_valid_i = 1'b0;
    check("after_train_pc", pc_o, 32'h84);
    jump_to(32'h20);
    check("alloc_pt", {31'b0, predict_taken_o}, bp(32'h1));
    check("alloc_pa", predict_addr_o, bp(32'h100));
    step();
    check("predicted_next_pc", pc_o, Bpu ? 32'h100 : 32'h24);

    // Three not-taken updates while parked at 0x20
    hold_flag_i = HOLD_PC;
    jump_to(32'h20);
    train(32'h20, 1'b0, 32'h300);
    step();
    check("nt1_pt", {31'b0, predict_taken_o}, 32'h0);
    check("nt1_pa", predict_addr_o, bp(32'h100));
    step();
    check("nt2_pt", {31'b0, predict_taken_o}, 32'h0);
    step();
    upd_valid_i = 1'b0;
    check("nt3_pt", {31'b0, predict_taken_o}, 32'h0);
    check("nt3_pa", predict_addr_o, bp(32'h100));
    hold_flag_i = HOLD_NONE;
    step();
    check("nt_next_pc", pc_o, 32'h24);

    // One taken from saturated-zero gives weakly not-taken
    train(32'h20, 1'b1, 32'h100);
    step();
    upd_valid_i = 1'b0;
    hold_flag_i = HOLD_PC;
    jump_to(32'h20);
    check("sat0_up_pt", {31'b0, predict_taken_o}, 32'h0);
    check("sat0_up_pa", predict_addr_o, bp(32'h100));

    // Alias 0x60 evicts 0x20; lookup same cycle sees old entry
    train(32'h60, 1'b1, 32'h200);
    check("alias_same_cycle_pa", predict_addr_o, bp(32'h100));
    step();
    upd_valid_i = 1'b0;
    check("alias_20_miss_pa", predict_addr_o, 32'h0);
    check("alias_20_miss_pt", {31'b0, predict_taken_o}, 32'h0);
    jump_to(32'h60);
    check("alias_60_pt", {31'b0, predict_taken_o}, bp(32'h1));
    check("alias_60_pa", predict_addr_o, bp(32'h200));
    train(32'h60, 1'b0, 32'h0);
    check("same_cycle_old_pt", {31'b0, predict_taken_o}, bp(32'h1));
    step();
    upd_valid_i = 1'b0;
    check("same_cycle_new_pt", {31'b0, predict_taken_o}, 32'h0);
    check("same_cycle_new_pa", predict_addr_o, bp(32'h200));

    // Wrap-around and misaligned redirect
    hold_flag_i = HOLD_NONE;
    jump_to(32'hFFFF_FFFC);
    check("wrap_pre", pc_o, 32'hFFFF_FFFC);
    step();
    check("wrap_post", pc_o, 32'h0);
    jump_to(32'h1002);
    check("misaligned_jump", pc_o, 32'h1002);
    step();
    check("misaligned_next", pc_o, 32'h1006);

    // Asynchronous reset mid-run with trained state present
    hold_flag_i = HOLD_PC;
    jump_to(32'h1234);
    check("pre_reset_pc", pc_o, 32'h1234);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_pc", pc_o, 32'h0);
    #1;
    rst = 1'b1;
    jump_to(32'h60);
    check("post_reset_pc", pc_o, 32'h60);
    check("post_reset_60_pt", {31'b0, predict_taken_o}, 32'h0);
    check("post_reset_60_pa", predict_addr_o, 32'h0);
    jump_to(32'h20);
    check("post_reset_20_pa", predict_addr_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
